// File: rtl/riscv_pkg.sv
// Shared RV32 core constants: datapath width, canonical NOP and the base opcodes that the
// ID-stage controller decodes.
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer. It parks the read that returns while fetch is stalled, so
// that the read can be replayed into IF/ID on the first unstalled edge.
module fetch_skid_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            capture,
  input  logic            drain,
  input  logic [31:0]     cap_instr,
  input  logic [PC_W-1:0] cap_pc,
  output logic            hold_valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      instr      <= '0;
      pc         <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture && !hold_valid) begin
      // First capture wins; the word is held for the rest of the stall.
      hold_valid <= 1'b1;
      instr      <= cap_instr;
      pc         <= cap_pc;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: the PC register, tracking of the one in-flight synchronous imem
// read, and the IF/ID register. It handles stalls through a skid buffer and EX redirects.
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall_in,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [31:0]        if_id_instr,
  output logic [XLEN-1:0]    if_id_pc,
  output logic               if_id_valid
);
  import riscv_pkg::*;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] req_pc;
  logic            req_valid;
  logic [XLEN-1:0] redirect_tgt;
  logic            hold_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  assign imem_addr    = pc_f[IMEM_AW+1:2];
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // A redirect discards the skid even when it coincides with a stall.
  fetch_skid_buf #(.PC_W(XLEN)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect_valid),
    .capture    (stall_in && req_valid),
    .drain      (!stall_in),
    .cap_instr  (imem_rdata),
    .cap_pc     (req_pc),
    .hold_valid (hold_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f        <= RESET_PC;
      req_valid   <= 1'b0;
      req_pc      <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (redirect_valid) begin
      pc_f        <= redirect_tgt;
      req_valid   <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (stall_in) begin
      req_valid   <= 1'b0;
    end else begin
      req_valid <= 1'b1;
      req_pc    <= pc_f;
      pc_f      <= pc_f + XLEN'(4);
      if (hold_valid) begin
        if_id_valid <= 1'b1;
        if_id_instr <= skid_instr;
        if_id_pc    <= skid_pc;
      end else begin
        // Bubbles carry a NOP rather than whatever the memory happens to return.
        if_id_valid <= req_valid;
        if_id_instr <= req_valid ? imem_rdata : NOP_INSTR;
        if_id_pc    <= req_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, stall/skid replay, redirects, reset mid-stall,
// and PC wrap on a second instance reset at 32'hFFFF_FFF8.
module tb_fetch_unit;
  localparam int AW = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_in, redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   if_id_instr, if_id_pc;
  logic          if_id_valid;

  logic          w_stall = 1'b0, w_redir = 1'b0;
  logic [31:0]   w_redir_pc = '0;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_rdata;
  logic [31:0]   w_instr, w_pc;
  logic          w_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous imem models: word k holds 32'h1000_0000 + k.
  always @(posedge clk) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
  always @(posedge clk) w_rdata    <= 32'h1000_0000 + 32'(w_addr);

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .IMEM_AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .IMEM_AW(AW)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall_in(w_stall), .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
    .if_id_instr(w_instr), .if_id_pc(w_pc), .if_id_valid(w_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, ".instr"}, if_id_instr, instr);
    if (v) chk({tag, ".pc"}, if_id_pc, pc);
  endtask

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk_ifid("reset", 1'b0, 32'h0, NOP);
    chk("reset.pc", if_id_pc, 32'h0);
    chk("reset.addr", 32'(imem_addr), 32'h0);
    chk("wrap.reset_addr", 32'(w_addr), 32'h3FE);

    // Startup: first valid two edges after release.
    rst_n = 1'b1;
    step();
    chk_ifid("start.e1", 1'b0, 32'h0, NOP);
    chk("wrap.e1_valid", 32'(w_valid), 32'h0);
    chk("wrap.e1_addr", 32'(w_addr), 32'h3FF);
    step();
    chk_ifid("start.e2", 1'b1, 32'h0, 32'h1000_0000);
    chk("wrap.e2_pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap.e2_instr", w_instr, 32'h1000_03FE);
    chk("wrap.e2_addr", 32'(w_addr), 32'h000);
    step();
    chk_ifid("start.e3", 1'b1, 32'h4, 32'h1000_0001);
    chk("wrap.e3_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap.e3_instr", w_instr, 32'h1000_03FF);
    step();
    chk_ifid("start.e4", 1'b1, 32'h8, 32'h1000_0002);
    chk("wrap.e4_pc", w_pc, 32'h0000_0000);
    chk("wrap.e4_instr", w_instr, 32'h1000_0000);
    chk("wrap.e4_valid", 32'(w_valid), 32'h1);

    // Three-cycle stall while IF/ID holds pc 8.
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid($sformatf("stall%0d", i), 1'b1, 32'h8, 32'h1000_0002);
    end
    stall_in = 1'b0;
    step(); chk_ifid("release.12", 1'b1, 32'hC,  32'h1000_0003);
    step(); chk_ifid("release.16", 1'b1, 32'h10, 32'h1000_0004);
    step(); chk_ifid("release.20", 1'b1, 32'h14, 32'h1000_0005);

    // Redirect during a stall; low address bits ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; stall_in = 1'b1;
    step(); chk_ifid("redir.b1", 1'b0, 32'h0, NOP);
    redirect_valid = 1'b0; stall_in = 1'b0;
    step(); chk_ifid("redir.b2", 1'b0, 32'h0, NOP);
    step(); chk_ifid("redir.100", 1'b1, 32'h100, 32'h1000_0040);
    step(); chk_ifid("redir.104", 1'b1, 32'h104, 32'h1000_0041);

    // Back-to-back redirects: 0x200 is squashed by 0x300.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); chk_ifid("b2b.r1", 1'b0, 32'h0, NOP);
    redirect_pc = 32'h300;
    step(); chk_ifid("b2b.r2", 1'b0, 32'h0, NOP);
    redirect_valid = 1'b0;
    step(); chk_ifid("b2b.bubble", 1'b0, 32'h0, NOP);
    step(); chk_ifid("b2b.300", 1'b1, 32'h300, 32'h1000_00C0);
    step(); chk_ifid("b2b.304", 1'b1, 32'h304, 32'h1000_00C1);

    // Reset mid-stall with a word parked in the skid: it must never emerge.
    stall_in = 1'b1;
    step(); chk_ifid("rststall.hold", 1'b1, 32'h304, 32'h1000_00C1);
    rst_n = 1'b0;
    step();
    chk_ifid("rststall.rst", 1'b0, 32'h0, NOP);
    chk("rststall.addr", 32'(imem_addr), 32'h0);
    rst_n = 1'b1; stall_in = 1'b0;
    step(); chk_ifid("rststall.e1", 1'b0, 32'h0, NOP);
    step(); chk_ifid("rststall.e2", 1'b1, 32'h0, 32'h1000_0000);
    step(); chk_ifid("rststall.e3", 1'b1, 32'h4, 32'h1000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
